input_port_buffer: RTL and testbench
====================================

# input_port_buffer

Per-input-port flit buffer and route latch for a router in the 4x4 mesh NoC. It sits directly upstream of the per-router XY route-compute block. It stores incoming flits in a small FIFO and presents the destination byte of the head flit at the FIFO front to route compute. It captures the one-hot port request that route compute returns and holds it for the whole packet, so the switch stage can drain body and tail flits under wormhole switching.

## Interface
- `DEPTH`, 4: FIFO depth in flits; power of two, at least 2.
- `FLIT_W`, 10: flit width. Bits [9:8] are the type: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single-flit packet (head and tail). Bits [7:0] are the payload; in a head flit, [3:2] is the destination x and [1:0] is the destination y.
- `clk`, input, 1: the only clock.
- `rst`, input, 1: reset, **asynchronous, active-low**.
- `flit_in`, input, FLIT_W: flit from the upstream link.
- `flit_valid_in`, input, 1: `flit_in` is valid this cycle.
- `ready_out`, output, 1: the buffer can accept a flit this cycle.
- `head_dest`, output, 8: payload [7:0] of the FIFO front; feeds the route-compute `Ni` input.
- `req_in`, input, 5: one-hot request from route compute. Bit [0]=L, [1]=E, [2]=W, [3]=S, [4]=N.
- `out_req`, output, 5: latched one-hot request to the switch stage.
- `grant_in`, input, 1: the switch accepts the current `flit_out` this cycle.
- `flit_out`, output, FLIT_W: FIFO front flit.
- `err`, output, 1: one-cycle protocol-error pulse.

## Operation
- FIFO uses read and write pointers plus an occupancy count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push happens when `flit_valid_in && ready_out`.
- `ready_out = (count < DEPTH)`. A pop in the same cycle does not raise `ready_out`, so there is no push on full.
- `flit_valid_in` while `ready_out=0` has no effect and the flit is lost. Avoiding this is the upstream's responsibility.
- Push and pop may occur in the same cycle; the count is then unchanged.
- `flit_out` and `head_dest` are combinational from the FIFO front. Both are don't-care when the FIFO is empty.
- State machine has two states, IDLE and ACTIVE.
  - **IDLE, front is head or single:** latch `req_in` into `route_reg` and move to ACTIVE. Nothing is popped.
  - **IDLE, captured `req_in` is zero:** stay in IDLE and raise `err`.
  - **IDLE, front is body or tail:** pop it (discard) and raise `err`.
  - **IDLE, FIFO empty:** no action.
  - **ACTIVE:** `out_req = route_reg` whenever the FIFO is non-empty, otherwise 0. On `grant_in && !empty`, pop the front.
  - **ACTIVE, popped flit is tail or single:** clear `route_reg` and return to IDLE.
  - **ACTIVE, popped flit is a head (type 2'b10):** forward it as a body flit and raise `err`.
- A `grant_in` with an empty FIFO or in IDLE is ignored.
- `out_req` is 0 in IDLE.

## Timing
- Reset values, asynchronous on `rst=0`:
  - pointers = 0, count = 0, state = IDLE
  - `route_reg` = 0, `out_req` = 0, `err` = 0
  - `ready_out` = 1
- Write to front visibility: a flit pushed at edge N is at the front, on `flit_out` and `head_dest`, during cycle N+1 if the FIFO was empty.
- Route latency: a head at the front in IDLE during cycle N gives `out_req` valid in cycle N+1. The earliest head pop is therefore edge N+1.
- Steady state in ACTIVE: one flit per cycle while `grant_in=1` and the FIFO is non-empty.
- Back-to-back packets: after a tail pops at edge M, the next head is routed during cycle M+1 and requested from cycle M+2, giving a one-cycle bubble.
- `err` is registered. It is high for exactly one cycle, the cycle after the offending event.
- Reset mid-packet: all state is discarded and buffered flits are lost. `out_req` drops to 0 immediately (asynchronously).

## Configuration
- `IBUF_ERR_CHECK_EN`:
  - **Defined:** `err` behaves as described above.
  - **Not defined:** `err` is tied to 0 and no error flops are built. Stray body/tail flits in IDLE are still discarded, and a zero `req_in` still holds IDLE.

## Test plan
- **Single head/tail packet:** router at (x=0,y=1). Push 10'h209 (head, dest x=2 y=1) then 10'h155 (tail), with `req_in`=5'b00010 from route compute. Require `head_dest`=8'h09, `out_req`=5'b00010 one cycle after the head reaches the front, two pops under `grant_in=1`, then IDLE with `out_req`=0.
- **Fill and stall:** push 4 flits with `grant_in=0`. Require `ready_out`=0 at count 4; a 5th push is dropped; `ready_out`=1 the cycle after one pop.
- **Simultaneous push/pop at count 2:** count stays 2 and data order is preserved. Also exercise pointer wrap after 6 flits through a DEPTH=4 FIFO.
- **Stray body in IDLE:** push 10'h033. Require it popped without grant; `err`=1 for one cycle when the macro is defined, 0 when it is not.
- **Head inside an ACTIVE packet:** sequence head, head, tail. Require all three forwarded under one `out_req`, with `err` pulsed once.
- **Reset mid-packet:** assert `rst=0` with 3 flits buffered. Require count 0, `out_req`=0, `ready_out`=1 immediately; after release a new head routes normally.

Source files
------------

// File: rtl/input_port_buffer.sv
// input_port_buffer: per-input-port flit FIFO plus wormhole route latch.
// The flit at the FIFO front feeds route compute through head_dest. The
// returned one-hot request is held in route_reg until the packet's tail or
// single flit is popped.
// Optional feature macro: IBUF_ERR_CHECK_EN. When it is defined, the
// registered one-cycle err pulse is built. When it is not defined, err is
// tied low.
// Handshakes:
//   - Upstream push: flit_valid_in && ready_out. A flit offered while
//     ready_out is low is dropped.
//   - Downstream pop in ACTIVE: grant_in && !empty.
//   - A grant offered in IDLE or with an empty FIFO is ignored.
// Debug outputs: state_dbg (0 = IDLE, 1 = ACTIVE) and count_dbg (occupancy).
module input_port_buffer #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_W-1:0]            flit_in,
    input  logic                         flit_valid_in,
    output logic                         ready_out,
    output logic [7:0]                   head_dest,
    input  logic [4:0]                   req_in,
    output logic [4:0]                   out_req,
    input  logic                         grant_in,
    output logic [FLIT_W-1:0]            flit_out,
    output logic                         err,
    output logic                         state_dbg,
    output logic [$clog2(DEPTH):0]       count_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t          state;
    logic [4:0]      route_reg;
    // Set while the head that opened the packet has not yet been popped.
    // Any later head popped inside the packet is a protocol error.
    logic            first_pending;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic [FLIT_W-1:0] front;
    logic [1:0]        front_type;
    logic              empty;
    logic              push;
    logic              pop;
    logic              idle_route;
    logic              idle_discard;
    logic              active_pop;
    logic              stray_head;

    assign front      = mem[rd_ptr];
    assign front_type = front[FLIT_W-1 -: 2];
    assign empty      = (count == '0);
    assign ready_out  = (count < CW'(DEPTH));
    assign push       = flit_valid_in && ready_out;

    // Type bit 1 marks head/single, type bit 0 marks tail/single.
    assign idle_route   = (state == IDLE) && !empty && front_type[1];
    assign idle_discard = (state == IDLE) && !empty && !front_type[1];
    assign active_pop   = (state == ACTIVE) && !empty && grant_in;
    assign stray_head   = (state == ACTIVE) && !first_pending && (front_type == 2'b10);
    assign pop          = idle_discard || active_pop;

    assign head_dest = front[7:0];
    // A head arriving inside an open packet is passed on as a body flit.
    assign flit_out  = stray_head ? {2'b00, front[FLIT_W-3:0]} : front;
    // out_req comes only from flops. Reset therefore clears it at once.
    assign out_req   = (state == ACTIVE && !empty) ? route_reg : 5'b00000;

    assign state_dbg = state;
    assign count_dbg = count;

    // Flit storage is written on push. It is not reset because contents
    // behind the pointers are don't-care.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= flit_in;
        end
    end

    // Pointers and occupancy. Pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Route FSM: latch the route on a front head, and release it when the
    // tail or single flit is popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            route_reg     <= 5'b00000;
            first_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_route && (req_in != 5'b00000)) begin
                        route_reg     <= req_in;
                        first_pending <= 1'b1;
                        state         <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (active_pop) begin
                        first_pending <= 1'b0;
                        if (front_type[0]) begin
                            route_reg <= 5'b00000;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IBUF_ERR_CHECK_EN
    logic err_q;
    logic err_next;

    assign err_next = (idle_route && (req_in == 5'b00000)) || idle_discard ||
                      (active_pop && stray_head);

    // Registered protocol-error pulse, high the cycle after the offending event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_next;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed testbench for input_port_buffer (DEPTH=4, FLIT_W=10).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// at the same point, when the edge's effects are settled.
module tb_input_port_buffer;

    logic       clk;
    logic       rst;
    logic [9:0] flit_in;
    logic       flit_valid_in;
    logic       ready_out;
    logic [7:0] head_dest;
    logic [4:0] req_in;
    logic [4:0] out_req;
    logic       grant_in;
    logic [9:0] flit_out;
    logic       err;
    logic       state_dbg;
    logic [2:0] count_dbg;

    int n_checks;
    int n_pass;

`ifdef IBUF_ERR_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    input_port_buffer #(.DEPTH(4), .FLIT_W(10)) dut (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid_in(flit_valid_in),
        .ready_out(ready_out), .head_dest(head_dest), .req_in(req_in),
        .out_req(out_req), .grant_in(grant_in), .flit_out(flit_out), .err(err),
        .state_dbg(state_dbg), .count_dbg(count_dbg)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] f, input logic g);
        flit_valid_in = v;
        flit_in       = f;
        grant_in      = g;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 10'h000, 1'b0);
        req_in = 5'b00000;
        tick();
        tick();
        n_checks++; if (ready_out !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_out); else n_pass++;
        n_checks++; if (out_req !== 5'b00000) $display("FAIL rst_out_req: got %b want 00000", out_req); else n_pass++;
        n_checks++; if ({err, state_dbg, count_dbg} !== 5'b00000) $display("FAIL rst_state: got err=%b st=%b cnt=%0d want 0/0/0", err, state_dbg, count_dbg); else n_pass++;
        #2 rst = 1'b1;
    endtask

    task automatic test_single_packet();
        req_in = 5'b00010;
        drive(1'b1, 10'h209, 1'b0);
        tick();
        n_checks++; if (head_dest !== 8'h09) $display("FAIL sp_head_dest: got %h want 09", head_dest); else n_pass++;
        n_checks++; if (out_req !== 5'b00000) $display("FAIL sp_idle_req: got %b want 00000", out_req); else n_pass++;
        drive(1'b1, 10'h155, 1'b0);
        tick();
        n_checks++; if (out_req !== 5'b00010) $display("FAIL sp_out_req: got %b want 00010", out_req); else n_pass++;
        n_checks++; if (flit_out !== 10'h209) $display("FAIL sp_flit_head: got %h want 209", flit_out); else n_pass++;
        drive(1'b0, 10'h000, 1'b1);
        tick();
        n_checks++; if (flit_out !== 10'h155 || out_req !== 5'b00010) $display("FAIL sp_tail_front: got %h/%b want 155/00010", flit_out, out_req); else n_pass++;
        tick();
        n_checks++; if ({state_dbg, count_dbg} !== 4'b0000 || out_req !== 5'b00000) $display("FAIL sp_done: got st=%b cnt=%0d req=%b want 0/0/00000", state_dbg, count_dbg, out_req); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL sp_err: got %b want 0", err); else n_pass++;
        drive(1'b0, 10'h000, 1'b0);
    endtask

    task automatic test_fill_stall();
        logic [9:0] exp_q[$];
        exp_q = '{10'h001, 10'h002, 10'h103};
        req_in = 5'b00010;
        drive(1'b1, 10'h209, 1'b0); tick();
        drive(1'b1, 10'h001, 1'b0); tick();
        drive(1'b1, 10'h002, 1'b0); tick();
        drive(1'b1, 10'h103, 1'b0); tick();
        n_checks++; if (ready_out !== 1'b0 || count_dbg !== 3'd4) $display("FAIL fs_full: got rdy=%b cnt=%0d want 0/4", ready_out, count_dbg); else n_pass++;
        drive(1'b1, 10'h0AA, 1'b0); tick();
        n_checks++; if (count_dbg !== 3'd4) $display("FAIL fs_drop: got cnt=%0d want 4", count_dbg); else n_pass++;
        drive(1'b0, 10'h000, 1'b1); tick();
        n_checks++; if (ready_out !== 1'b1 || count_dbg !== 3'd3) $display("FAIL fs_ready_after_pop: got rdy=%b cnt=%0d want 1/3", ready_out, count_dbg); else n_pass++;
        while (exp_q.size() > 0) begin
            n_checks++; if (flit_out !== exp_q[0]) $display("FAIL fs_order: got %h want %h", flit_out, exp_q[0]); else n_pass++;
            void'(exp_q.pop_front());
            tick();
        end
        n_checks++; if (count_dbg !== 3'd0 || state_dbg !== 1'b0) $display("FAIL fs_drained: got cnt=%0d st=%b want 0/0", count_dbg, state_dbg); else n_pass++;
        drive(1'b0, 10'h000, 1'b0);
    endtask

    task automatic test_push_pop_wrap();
        req_in = 5'b01000;
        drive(1'b1, 10'h209, 1'b0); tick();
        drive(1'b1, 10'h011, 1'b1); tick();
        n_checks++; if (count_dbg !== 3'd2 || out_req !== 5'b01000) $display("FAIL pp_setup: got cnt=%0d req=%b want 2/01000", count_dbg, out_req); else n_pass++;
        drive(1'b1, 10'h012, 1'b1); tick();
        n_checks++; if (count_dbg !== 3'd2 || flit_out !== 10'h011) $display("FAIL pp_step1: got cnt=%0d f=%h want 2/011", count_dbg, flit_out); else n_pass++;
        drive(1'b1, 10'h013, 1'b1); tick();
        n_checks++; if (count_dbg !== 3'd2 || flit_out !== 10'h012) $display("FAIL pp_step2: got cnt=%0d f=%h want 2/012", count_dbg, flit_out); else n_pass++;
        drive(1'b1, 10'h114, 1'b1); tick();
        n_checks++; if (count_dbg !== 3'd2 || flit_out !== 10'h013) $display("FAIL pp_step3_wrap: got cnt=%0d f=%h want 2/013", count_dbg, flit_out); else n_pass++;
        drive(1'b0, 10'h000, 1'b1); tick();
        n_checks++; if (count_dbg !== 3'd1 || flit_out !== 10'h114) $display("FAIL pp_tail: got cnt=%0d f=%h want 1/114", count_dbg, flit_out); else n_pass++;
        tick();
        n_checks++; if (count_dbg !== 3'd0 || out_req !== 5'b00000 || err !== 1'b0) $display("FAIL pp_done: got cnt=%0d req=%b err=%b want 0/00000/0", count_dbg, out_req, err); else n_pass++;
        drive(1'b0, 10'h000, 1'b0);
    endtask

    task automatic test_stray_body();
        drive(1'b1, 10'h033, 1'b0); tick();
        n_checks++; if (count_dbg !== 3'd1 || flit_out !== 10'h033) $display("FAIL sb_front: got cnt=%0d f=%h want 1/033", count_dbg, flit_out); else n_pass++;
        drive(1'b0, 10'h000, 1'b0); tick();
        n_checks++; if (count_dbg !== 3'd0 || state_dbg !== 1'b0) $display("FAIL sb_discard: got cnt=%0d st=%b want 0/0", count_dbg, state_dbg); else n_pass++;
        n_checks++; if (err !== ERR_ON) $display("FAIL sb_err_pulse: got %b want %b", err, ERR_ON); else n_pass++;
        tick();
        n_checks++; if (err !== 1'b0) $display("FAIL sb_err_clear: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_zero_req();
        req_in = 5'b00000;
        drive(1'b1, 10'h209, 1'b0); tick();
        drive(1'b0, 10'h000, 1'b0); tick();
        n_checks++; if (state_dbg !== 1'b0 || count_dbg !== 3'd1 || err !== ERR_ON) $display("FAIL zr_hold: got st=%b cnt=%0d err=%b want 0/1/%b", state_dbg, count_dbg, err, ERR_ON); else n_pass++;
        req_in = 5'b00001;
        drive(1'b1, 10'h155, 1'b0); tick();
        n_checks++; if (out_req !== 5'b00001 || err !== 1'b0) $display("FAIL zr_route: got req=%b err=%b want 00001/0", out_req, err); else n_pass++;
        drive(1'b0, 10'h000, 1'b1); tick(); tick();
        n_checks++; if (count_dbg !== 3'd0 || state_dbg !== 1'b0) $display("FAIL zr_done: got cnt=%0d st=%b want 0/0", count_dbg, state_dbg); else n_pass++;
        drive(1'b0, 10'h000, 1'b0);
    endtask

    task automatic test_head_in_packet();
        int pulses;
        pulses = 0;
        req_in = 5'b00010;
        drive(1'b1, 10'h209, 1'b1); tick();
        drive(1'b1, 10'h20A, 1'b1); tick();
        drive(1'b1, 10'h155, 1'b1); tick();
        pulses += int'(err);
        n_checks++; if (flit_out !== 10'h00A || out_req !== 5'b00010) $display("FAIL hp_as_body: got %h/%b want 00a/00010", flit_out, out_req); else n_pass++;
        drive(1'b0, 10'h000, 1'b1); tick();
        pulses += int'(err);
        n_checks++; if (flit_out !== 10'h155 || out_req !== 5'b00010 || err !== ERR_ON) $display("FAIL hp_err: got %h/%b err=%b want 155/00010/%b", flit_out, out_req, err, ERR_ON); else n_pass++;
        tick();
        pulses += int'(err);
        n_checks++; if (pulses !== int'(ERR_ON) || out_req !== 5'b00000 || count_dbg !== 3'd0) $display("FAIL hp_done: got pulses=%0d req=%b cnt=%0d want %0d/00000/0", pulses, out_req, count_dbg, int'(ERR_ON)); else n_pass++;
        drive(1'b0, 10'h000, 1'b0);
    endtask

    task automatic test_back_to_back();
        req_in = 5'b00100;
        drive(1'b1, 10'h209, 1'b1); tick();
        drive(1'b1, 10'h155, 1'b1); tick();
        drive(1'b1, 10'h20A, 1'b1); tick();
        drive(1'b1, 10'h1AA, 1'b1); tick();
        n_checks++; if (out_req !== 5'b00000 || state_dbg !== 1'b0 || flit_out !== 10'h20A) $display("FAIL bb_bubble: got req=%b st=%b f=%h want 00000/0/20a", out_req, state_dbg, flit_out); else n_pass++;
        drive(1'b0, 10'h000, 1'b1); tick();
        n_checks++; if (out_req !== 5'b00100 || flit_out !== 10'h20A) $display("FAIL bb_second: got req=%b f=%h want 00100/20a", out_req, flit_out); else n_pass++;
        tick(); tick();
        n_checks++; if (count_dbg !== 3'd0 || state_dbg !== 1'b0) $display("FAIL bb_done: got cnt=%0d st=%b want 0/0", count_dbg, state_dbg); else n_pass++;
        drive(1'b0, 10'h000, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        req_in = 5'b00010;
        drive(1'b1, 10'h209, 1'b0); tick();
        drive(1'b1, 10'h001, 1'b0); tick();
        drive(1'b1, 10'h002, 1'b0); tick();
        drive(1'b0, 10'h000, 1'b0);
        n_checks++; if (count_dbg !== 3'd3 || out_req !== 5'b00010) $display("FAIL rm_before: got cnt=%0d req=%b want 3/00010", count_dbg, out_req); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (count_dbg !== 3'd0 || out_req !== 5'b00000 || ready_out !== 1'b1) $display("FAIL rm_async: got cnt=%0d req=%b rdy=%b want 0/00000/1", count_dbg, out_req, ready_out); else n_pass++;
        #1 rst = 1'b1;
        req_in = 5'b10000;
        drive(1'b1, 10'h2C3, 1'b0); tick();
        n_checks++; if (head_dest !== 8'hC3 || out_req !== 5'b00000) $display("FAIL rm_new_head: got %h/%b want c3/00000", head_dest, out_req); else n_pass++;
        drive(1'b1, 10'h1FF, 1'b0); tick();
        n_checks++; if (out_req !== 5'b10000) $display("FAIL rm_route: got %b want 10000", out_req); else n_pass++;
        drive(1'b0, 10'h000, 1'b1); tick(); tick();
        n_checks++; if (count_dbg !== 3'd0 || out_req !== 5'b00000) $display("FAIL rm_done: got cnt=%0d req=%b want 0/00000", count_dbg, out_req); else n_pass++;
        drive(1'b0, 10'h000, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single_packet();
        test_fill_stall();
        test_push_pop_wrap();
        test_stray_body();
        test_zero_req();
        test_head_in_packet();
        test_back_to_back();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
